// File: rtl/mips_instr_encoder_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS instruction encoder slice:
//   - primary opcode constants for the supported instruction formats
//   - in_kind request codes (values 6 and 7 are illegal)
//   - encoder FSM state enum
//   - output FIFO entry layout (encoded word plus its memory address)
//   - helper functions for kind legality and word encoding
// No ports; imported by the interface users, the FIFO and the top level.
// ----------------------------------------------------------------------------
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [2:0] KIND_R    = 3'd0;
    localparam logic [2:0] KIND_LW   = 3'd1;
    localparam logic [2:0] KIND_SW   = 3'd2;
    localparam logic [2:0] KIND_BEQ  = 3'd3;
    localparam logic [2:0] KIND_BNE  = 3'd4;
    localparam logic [2:0] KIND_ADDI = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
    } fifo_entry_t;

    function automatic logic is_legal_kind(input logic [2:0] kind);
        return (kind <= KIND_ADDI);
    endfunction

    // rd and funct only participate in the R-type format; I-type words
    // carry the 16-bit immediate in their low half instead.
    function automatic logic [31:0] encode(
        input logic [2:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [5:0]  funct,
        input logic [15:0] imm
    );
        logic [31:0] word;
        word = '0;
        case (kind)
            KIND_R:    word = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
            KIND_LW:   word = {OP_LW,   rs, rt, imm};
            KIND_SW:   word = {OP_SW,   rs, rt, imm};
            KIND_BEQ:  word = {OP_BEQ,  rs, rt, imm};
            KIND_BNE:  word = {OP_BNE,  rs, rt, imm};
            KIND_ADDI: word = {OP_ADDI, rs, rt, imm};
            default:   word = '0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/mips_instr_encoder_if.sv
// ----------------------------------------------------------------------------
// mips_instr_encoder_if
// Request and output-word buses of the MIPS instruction encoder.
//   Request side : in_valid/in_ready handshake, in_kind, in_rs, in_rt, in_rd,
//                  in_funct, in_imm
//   Output side  : out_valid/out_ready handshake, out_instr, out_addr
// Modports:
//   master - the producer of requests and consumer of encoded words
//   slave  - the encoder itself
// ----------------------------------------------------------------------------
interface mips_instr_encoder_if;

    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_kind;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;

    modport master (
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm,
        output out_ready,
        input  in_ready,
        input  out_valid, out_instr, out_addr
    );

    modport slave (
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm,
        input  out_ready,
        output in_ready,
        output out_valid, out_instr, out_addr
    );

endinterface

// File: rtl/mips_instr_encoder_fifo.sv
// ----------------------------------------------------------------------------
// mips_instr_fifo
// Output buffer of the encoder: DEPTH entries of {instr, addr} (64 bits).
// Ports:
//   clk, rst   - clock, synchronous active-high reset (flushes all entries)
//   push       - write push_data this cycle (ignored when full)
//   push_data  - entry to enqueue
//   pop        - retire the head entry this cycle (ignored when empty)
//   pop_data   - head entry, forced to zero while empty
//   full/empty - occupancy flags derived from registered state only
// DEPTH must be a power of two >= 2 so the index counters wrap naturally.
// ----------------------------------------------------------------------------
module mips_instr_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  fifo_entry_t push_data,
    input  logic        pop,
    output fifo_entry_t pop_data,
    output logic        full,
    output logic        empty
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

    fifo_entry_t      mem [DEPTH];
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic [AW:0]      occupancy;
    logic             do_push;
    logic             do_pop;

    assign full    = (occupancy == FULL_COUNT);
    assign empty   = (occupancy == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Zeroing the head while empty keeps out_instr/out_addr at zero after
    // reset without having to clear the storage array.
    assign pop_data = empty ? '0 : mem[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx    <= '0;
            rd_idx    <= '0;
            occupancy <= '0;
        end else begin
            if (do_push) begin
                wr_idx <= wr_idx + AW'(1);
            end
            if (do_pop) begin
                rd_idx <= rd_idx + AW'(1);
            end
            // A simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   occupancy <= occupancy + (AW+1)'(1);
                2'b01:   occupancy <= occupancy - (AW+1)'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// ----------------------------------------------------------------------------
// mips_instr_encoder
// Accepts a sequence of instruction requests, encodes each legal one into a
// 32-bit MIPS word and emits it together with its instruction-memory address
// (base + 4*k, wrapping modulo 2^32) through a small output FIFO.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   start      - begins a sequence when idle; latches base_addr and len
//   base_addr  - address of the first emitted word (low two bits dropped)
//   len        - number of legal instructions in the sequence
//   busy       - high whenever the FSM is not idle
//   done       - single-cycle pulse marking the end of a sequence
//   err        - sticky flag, set when an illegal in_kind is accepted
//   bus        - request and output-word handshakes (slave side)
// ----------------------------------------------------------------------------
module mips_instr_encoder
    import mips_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [31:0]            base_addr,
    input  logic [7:0]             len,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    mips_instr_encoder_if.slave    bus
);

    state_t       state;
    logic [7:0]   len_reg;
    logic [7:0]   count;
    logic [31:0]  next_addr;
    logic         err_reg;

    logic         in_fire;
    logic         kind_legal;
    logic         push;
    logic         fifo_full;
    logic         fifo_empty;
    fifo_entry_t  push_data;
    fifo_entry_t  pop_data;

    // Requests are only taken while running and there is room to store the
    // result; a full FIFO blocks input even if the consumer pops this cycle.
    assign bus.in_ready = (state == ST_RUN) && !fifo_full;
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign kind_legal   = is_legal_kind(bus.in_kind);
    assign push         = in_fire && kind_legal;

    assign push_data.instr = encode(bus.in_kind, bus.in_rs, bus.in_rt,
                                    bus.in_rd, bus.in_funct, bus.in_imm);
    assign push_data.addr  = next_addr;

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);
    assign err  = err_reg;

    // Sequencer. The address is attached at enqueue time so FIFO order alone
    // guarantees that the k-th emitted word carries base + 4*k.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            len_reg   <= '0;
            count     <= '0;
            next_addr <= '0;
            err_reg   <= 1'b0;
        end else begin
            if (in_fire && !kind_legal) begin
                err_reg <= 1'b1;
            end
            if (push) begin
                next_addr <= next_addr + 32'd4;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_reg   <= len;
                        count     <= '0;
                        next_addr <= base_addr & 32'hFFFF_FFFC;
                        state     <= (len == 8'd0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (push) begin
                        count <= count + 8'd1;
                        if (count + 8'd1 == len_reg) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    mips_instr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (bus.out_ready),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_instr = pop_data.instr;
    assign bus.out_addr  = pop_data.addr;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// ----------------------------------------------------------------------------
// tb_mips_instr_encoder
// Directed bench for mips_instr_encoder. Stimulus tasks push hand-computed
// {instr, addr} expectations into a scoreboard queue as each legal request is
// accepted; an independent monitor pops and compares on every output
// handshake.
// ----------------------------------------------------------------------------
module tb_mips_instr_encoder;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [7:0]  len = '0;
    logic        busy;
    logic        done;
    logic        err;

    mips_instr_encoder_if bus();

    mips_instr_encoder #(
        .FIFO_DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every output handshake must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_word: got instr 0x%08h addr 0x%08h, expected none",
                         bus.out_instr, bus.out_addr);
            end else begin
                e = sb.pop_front();
                checkOutput("out_instr", bus.out_instr, e.instr);
                checkOutput("out_addr", bus.out_addr, e.addr);
            end
        end
    end

    task automatic startSeq(input logic [31:0] base, input logic [7:0] n);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = base;
        len       = n;
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = 32'hDEAD_BEEF;
        len       = 8'hFF;
    endtask

    task automatic driveReq(input logic [2:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm);
        @(posedge clk);
        #1;
        bus.in_kind  = kind;
        bus.in_rs    = rs;
        bus.in_rt    = rt;
        bus.in_rd    = rd;
        bus.in_funct = funct;
        bus.in_imm   = imm;
        bus.in_valid = 1'b1;
    endtask

    task automatic acceptReq(input logic [31:0] exp_instr, input logic [31:0] exp_addr,
                             input bit expect_out);
        int waited;
        bit ok;
        waited = 0;
        ok = 1'b0;
        while (waited < 200) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            waited++;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 for 200 cycles, expected 1");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (ok && expect_out) begin
            sb.push_back('{instr: exp_instr, addr: exp_addr});
        end
    endtask

    task automatic applyStimulus(input logic [2:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm,
                                 input logic [31:0] exp_instr, input logic [31:0] exp_addr,
                                 input bit expect_out);
        driveReq(kind, rs, rt, rd, funct, imm);
        acceptReq(exp_instr, exp_addr, expect_out);
    endtask

    task automatic waitDone(input string name);
        int cycles;
        bit seen;
        logic prev_valid;
        cycles = 0;
        seen = 1'b0;
        prev_valid = 1'b1;
        while (cycles < 200) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            prev_valid = bus.out_valid;
            cycles++;
        end
        checkOutput({name, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            checkOutput({name, "_fifo_empty_before_done"}, 32'(prev_valid), 32'd0);
            checkOutput({name, "_all_words_out"}, 32'(sb.size()), 32'd0);
            @(negedge clk);
            checkOutput({name, "_done_one_cycle"}, 32'(done), 32'd0);
            checkOutput({name, "_idle_after_done"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int done_count;
        int valid_count;

        bus.in_valid  = 1'b0;
        bus.in_kind   = '0;
        bus.in_rs     = '0;
        bus.in_rt     = '0;
        bus.in_rd     = '0;
        bus.in_funct  = '0;
        bus.in_imm    = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_out_instr", bus.out_instr, 32'd0);
        checkOutput("rst_out_addr", bus.out_addr, 32'd0);

        // Single R-type word.
        bus.out_ready = 1'b1;
        startSeq(32'h0040_0000, 8'd1);
        @(negedge clk);
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        applyStimulus(KIND_R, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0000,
                      32'h0022_1820, 32'h0040_0000, 1'b1);
        waitDone("seq_r");

        // LW then BNE; a start pulse mid-sequence must be ignored.
        startSeq(32'h0000_1000, 8'd2);
        applyStimulus(KIND_LW, 5'd29, 5'd8, 5'd0, 6'h00, 16'h0004,
                      32'h8FA8_0004, 32'h0000_1000, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = 32'h0000_5550;
        len = 8'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        applyStimulus(KIND_BNE, 5'd7, 5'd0, 5'd0, 6'h00, 16'h0003,
                      32'h14E0_0003, 32'h0000_1004, 1'b1);
        waitDone("seq_lw");

        // Backpressure: two words fill the FIFO, the third waits.
        bus.out_ready = 1'b0;
        startSeq(32'h0000_2000, 8'd3);
        applyStimulus(KIND_SW, 5'd3, 5'd4, 5'd0, 6'h00, 16'h0010,
                      32'hAC64_0010, 32'h0000_2000, 1'b1);
        applyStimulus(KIND_BEQ, 5'd5, 5'd6, 5'd0, 6'h00, 16'hFFFE,
                      32'h10A6_FFFE, 32'h0000_2004, 1'b1);
        driveReq(KIND_ADDI, 5'd1, 5'd2, 5'd0, 6'h00, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("full_in_ready", 32'(bus.in_ready), 32'd0);
            checkOutput("hold_out_addr", bus.out_addr, 32'h0000_2000);
            checkOutput("hold_out_instr", bus.out_instr, 32'hAC64_0010);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        acceptReq(32'h2022_1234, 32'h0000_2008, 1'b1);
        waitDone("seq_bp");

        // Illegal kind completes the handshake but produces nothing.
        startSeq(32'h0000_3000, 8'd1);
        applyStimulus(3'd7, 5'd1, 5'd2, 5'd3, 6'h04, 16'h0005,
                      32'h0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("err_after_illegal", 32'(err), 32'd1);
        applyStimulus(KIND_ADDI, 5'd0, 5'd9, 5'd31, 6'h3F, 16'hFFFF,
                      32'h2009_FFFF, 32'h0000_3000, 1'b1);
        waitDone("seq_illegal");

        // Address wrap at the top of the address space.
        startSeq(32'hFFFF_FFFC, 8'd2);
        applyStimulus(KIND_R, 5'd31, 5'd31, 5'd31, 6'h2A, 16'h0000,
                      32'h03FF_F82A, 32'hFFFF_FFFC, 1'b1);
        applyStimulus(KIND_SW, 5'd3, 5'd4, 5'd0, 6'h00, 16'h0010,
                      32'hAC64_0010, 32'h0000_0000, 1'b1);
        waitDone("seq_wrap");
        checkOutput("err_sticky", 32'(err), 32'd1);

        // Zero-length sequence goes straight to DONE.
        startSeq(32'h0000_7000, 8'd0);
        @(negedge clk);
        checkOutput("len0_done", 32'(done), 32'd1);
        checkOutput("len0_busy", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("len0_done_cleared", 32'(done), 32'd0);
        checkOutput("len0_idle", 32'(busy), 32'd0);

        // Reset with two words queued discards them and suppresses done.
        bus.out_ready = 1'b0;
        startSeq(32'h0000_4000, 8'd4);
        applyStimulus(KIND_R, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0000,
                      32'h0, 32'h0, 1'b0);
        applyStimulus(KIND_LW, 5'd29, 5'd8, 5'd0, 6'h00, 16'h0004,
                      32'h0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("queued_before_rst", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_err", 32'(err), 32'd0);
        checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        done_count = 0;
        valid_count = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) done_count++;
            if (bus.out_valid) valid_count++;
        end
        checkOutput("no_done_after_rst", 32'(done_count), 32'd0);
        checkOutput("no_words_after_rst", 32'(valid_count), 32'd0);

        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
